// File: rtl/oam_dma_pkg.sv
// Shared PPU / memory-map constants and helpers used by the OAM DMA engine.
// Holds the DMA register address, HRAM window and DMA state encoding.
package oam_dma_pkg;

  localparam logic [15:0] REG_DMA_ADDR = 16'hFF46;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET  = 8'h20;
  localparam int          TMR_W        = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_GAP   = 3'd4
  } dma_state_e;

  // Echo RAM pages alias the work RAM 0x20 pages below them.
  function automatic logic [7:0] map_src_page(input logic [7:0] page);
    logic [7:0] mapped;
    if (page >= ECHO_BASE) begin
      mapped = page - ECHO_OFFSET;
    end else begin
      mapped = page;
    end
    return mapped;
  endfunction

  function automatic logic cpu_blocked(input logic [15:0] addr, input logic dma_on);
    return dma_on && !((addr >= HRAM_LO) && (addr <= HRAM_HI));
  endfunction

endpackage

// File: rtl/dma_slot_timer.sv
// Down-counter that times the START phase and the per-byte GAP phase.
// Loading a length L asserts o_last on the L-th clock after the load.
module dma_slot_timer
  import oam_dma_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [TMR_W-1:0] i_len,
  output logic             o_last
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= {TMR_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_len - TMR_W'(1);
    end else if (r_cnt != {TMR_W{1'b0}}) begin
      r_cnt <= r_cnt - TMR_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_last = (r_cnt == {TMR_W{1'b0}});

endmodule

// File: rtl/oam_dma.sv
// OAM DMA engine: a write to 0xFF46 copies BYTES bytes from page src_hi into OAM,
// one READ/WRITE slot every CLKS_PER_BYTE clocks after a START delay.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int BYTES         = 160,
  parameter int CLKS_PER_BYTE = 4,
  parameter int START_CLKS    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_data_write,
  input  logic        mem_do_write,
  output logic [7:0]  mem_data_read,
  output logic        mem_data_active,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_data_read,
  output logic        dma_bus_req,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_write,
  output logic        oam_do_write,
  output logic        dma_active
);

  localparam logic [7:0]       LAST_N    = 8'(BYTES - 1);
  localparam logic [TMR_W-1:0] START_LEN = TMR_W'(START_CLKS);
  localparam logic [TMR_W-1:0] GAP_LEN   = TMR_W'(CLKS_PER_BYTE - 2);
  localparam bit               HAS_START = (START_CLKS > 0);
  localparam bit               HAS_GAP   = (CLKS_PER_BYTE > 2);

  dma_state_e       r_state;
  dma_state_e       w_state_nxt;
  logic [7:0]       r_n;
  logic [7:0]       w_n_nxt;
  logic [7:0]       r_src_hi;
  logic [7:0]       r_src_map;
  logic [7:0]       w_src_map_nxt;
  logic [7:0]       r_oam_data;
  logic [15:0]      r_dma_addr;
  logic [7:0]       r_oam_addr;
  logic             r_bus_req;
  logic             r_oam_we;
  logic             r_active;
  logic             w_trig;
  logic             w_reg_hit;
  logic             w_tmr_load;
  logic             w_tmr_last;
  logic [TMR_W-1:0] w_tmr_len;

  assign w_reg_hit = (mem_addr == REG_DMA_ADDR);
  assign w_trig    = mem_do_write && w_reg_hit;

  dma_slot_timer u_slot_timer (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_load    (w_tmr_load),
    .i_len     (w_tmr_len),
    .o_last    (w_tmr_last)
  );

  // A trigger overrides every state, including the end of the final slot.
  always_comb begin
    w_state_nxt   = r_state;
    w_n_nxt       = r_n;
    w_tmr_load    = 1'b0;
    w_tmr_len     = START_LEN;
    w_src_map_nxt = r_src_map;
    if (w_trig) begin
      w_n_nxt       = 8'h00;
      w_src_map_nxt = map_src_page(mem_data_write);
      if (HAS_START) begin
        w_state_nxt = ST_START;
        w_tmr_load  = 1'b1;
      end else begin
        w_state_nxt = ST_READ;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_START: begin
          if (w_tmr_last) begin
            w_state_nxt = ST_READ;
          end else begin
            w_state_nxt = ST_START;
          end
        end
        ST_READ: begin
          w_state_nxt = ST_WRITE;
        end
        ST_WRITE: begin
          if (HAS_GAP) begin
            w_state_nxt = ST_GAP;
            w_tmr_load  = 1'b1;
            w_tmr_len   = GAP_LEN;
          end else if (r_n == LAST_N) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_n_nxt     = r_n + 8'd1;
            w_state_nxt = ST_READ;
          end
        end
        ST_GAP: begin
          if (!w_tmr_last) begin
            w_state_nxt = ST_GAP;
          end else if (r_n == LAST_N) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_n_nxt     = r_n + 8'd1;
            w_state_nxt = ST_READ;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus/OAM outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_n        <= 8'h00;
      r_src_hi   <= 8'h00;
      r_src_map  <= 8'h00;
      r_active   <= 1'b0;
      r_bus_req  <= 1'b0;
      r_oam_we   <= 1'b0;
      r_dma_addr <= 16'h0000;
      r_oam_addr <= 8'h00;
      r_oam_data <= 8'h00;
    end else begin
      r_n       <= w_n_nxt;
      r_src_map <= w_src_map_nxt;
      r_active  <= (w_state_nxt != ST_IDLE);
      r_bus_req <= (w_state_nxt == ST_READ) || (w_state_nxt == ST_WRITE);
      r_oam_we  <= (w_state_nxt == ST_WRITE);
      if (w_trig) begin
        r_src_hi <= mem_data_write;
      end else begin
        r_src_hi <= r_src_hi;
      end
      if (w_state_nxt == ST_READ) begin
        r_dma_addr <= {w_src_map_nxt, w_n_nxt};
      end else begin
        r_dma_addr <= r_dma_addr;
      end
      if (w_state_nxt == ST_WRITE) begin
        r_oam_addr <= w_n_nxt;
      end else begin
        r_oam_addr <= r_oam_addr;
      end
      if (r_state == ST_WRITE) begin
        r_oam_data <= dma_data_read;
      end else begin
        r_oam_data <= r_oam_data;
      end
    end
  end

  assign mem_data_read   = w_reg_hit ? r_src_hi : 8'hFF;
  assign mem_data_active = !mem_do_write && w_reg_hit;
  assign dma_addr        = r_dma_addr;
  assign dma_bus_req     = r_bus_req;
  assign oam_addr        = r_oam_addr;
  assign oam_do_write    = r_oam_we;
  assign dma_active      = r_active;
  // Bus data is only valid during WRITE; elsewhere the last stored byte is held.
  assign oam_data_write  = (r_state == ST_WRITE) ? dma_data_read : r_oam_data;

endmodule
